// File: rtl/beat_ram_sequencer.sv
// Time-slots one shared single-port beat RAM between two loop tracks:
// every accepted tick gives track A one access cycle, then track B one.
module beat_ram_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick,
  input  logic              rec_a,
  input  logic              rec_b,
  input  logic              play_a,
  input  logic              play_b,
  input  logic [DATA_W-1:0] live_data,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [DATA_W-1:0] play_data_a,
  output logic [DATA_W-1:0] play_data_b,
  output logic              valid_a,
  output logic              valid_b,
  output logic [ADDR_W-1:0] len_a,
  output logic [ADDR_W-1:0] len_b,
  output logic              full_a,
  output logic              full_b,
  output logic              overrun
);
  localparam int PW = ADDR_W - 1;
  // Lengths carry one extra bit so a completely filled region (2^PW samples) is representable.
  localparam logic [ADDR_W-1:0] REGION = ADDR_W'(1) << PW;

  typedef enum logic [1:0] {IDLE, SLOT_A, SLOT_B, FLUSH} state_t;
  typedef enum logic [1:0] {M_OFF, M_REC, M_PLAY} mode_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [PW-1:0]     ptr;
    logic [ADDR_W-1:0] len;
    logic              full;
  } step_t;

  state_t            state_q, state_d;
  mode_t             mode_q [2];
  mode_t             mode_d [2];
  logic [PW-1:0]     ptr_q [2];
  logic [PW-1:0]     ptr_d [2];
  logic [ADDR_W-1:0] len_q [2];
  logic [ADDR_W-1:0] len_d [2];
  logic [DATA_W-1:0] pdata_q [2];
  logic [DATA_W-1:0] pdata_d [2];
  logic [1:0]        full_q, full_d;
  logic [1:0]        valid_q, valid_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              overrun_q, overrun_d;
  logic [1:0]        req_rec, req_play;
  step_t             st;

  assign req_rec  = {rec_b, rec_a};
  assign req_play = {play_b, play_a};

  // One slot's RAM command and pointer/length bookkeeping for a track.
  function automatic step_t slot_step(input logic trk, input mode_t m, input logic [PW-1:0] p,
                                      input logic [ADDR_W-1:0] l, input logic f);
    step_t             s;
    logic [ADDR_W-1:0] nxt;
    nxt    = {1'b0, p} + ADDR_W'(1);
    s.addr = '0;
    s.we   = 1'b0;
    s.ptr  = p;
    s.len  = l;
    s.full = f;
    if (m == M_REC && !f) begin
      s.addr = {trk, p};
      s.we   = 1'b1;
      s.ptr  = p + PW'(1);
      s.len  = nxt;
      s.full = (nxt == REGION);
    end else if (m == M_PLAY && l != '0) begin
      s.addr = {trk, p};
      s.ptr  = (nxt == l) ? '0 : p + PW'(1);
    end
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = '0;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    overrun_d   = tick && (state_q != IDLE);
    valid_d     = '0;
    full_d      = full_q;
    st          = '0;
    for (int t = 0; t < 2; t++) begin
      mode_d[t]  = mode_q[t];
      ptr_d[t]   = ptr_q[t];
      len_d[t]   = len_q[t];
      pdata_d[t] = pdata_q[t];
    end
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d     = SLOT_A;
          ram_wdata_d = live_data;
          for (int t = 0; t < 2; t++) begin
            mode_d[t] = req_play[t] ? M_PLAY : (req_rec[t] ? M_REC : M_OFF);
            if (mode_d[t] == M_OFF) begin
              ptr_d[t] = '0;
            end else if (mode_d[t] != mode_q[t]) begin
              ptr_d[t] = '0;
              if (mode_d[t] == M_REC) begin
                len_d[t]  = '0;
                full_d[t] = 1'b0;
              end
            end
          end
          // Track A's command must be registered now so it is on the bus during SLOT_A.
          st         = slot_step(1'b0, mode_d[0], ptr_d[0], len_d[0], full_d[0]);
          ram_addr_d = st.addr;
          ram_we_d   = st.we;
          ptr_d[0]   = st.ptr;
          len_d[0]   = st.len;
          full_d[0]  = st.full;
        end
      end
      SLOT_A: begin
        state_d    = SLOT_B;
        st         = slot_step(1'b1, mode_q[1], ptr_q[1], len_q[1], full_q[1]);
        ram_addr_d = st.addr;
        ram_we_d   = st.we;
        ptr_d[1]   = st.ptr;
        len_d[1]   = st.len;
        full_d[1]  = st.full;
      end
      SLOT_B: begin
        state_d = FLUSH;
        if (mode_q[0] == M_PLAY) begin
          valid_d[0] = 1'b1;
          pdata_d[0] = (len_q[0] != '0) ? ram_rdata : '0;
        end
      end
      FLUSH: begin
        state_d = IDLE;
        if (mode_q[1] == M_PLAY) begin
          valid_d[1] = 1'b1;
          pdata_d[1] = (len_q[1] != '0) ? ram_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      overrun_q   <= 1'b0;
      valid_q     <= '0;
      full_q      <= '0;
      for (int t = 0; t < 2; t++) begin
        mode_q[t]  <= M_OFF;
        ptr_q[t]   <= '0;
        len_q[t]   <= '0;
        pdata_q[t] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      overrun_q   <= overrun_d;
      valid_q     <= valid_d;
      full_q      <= full_d;
      for (int t = 0; t < 2; t++) begin
        mode_q[t]  <= mode_d[t];
        ptr_q[t]   <= ptr_d[t];
        len_q[t]   <= len_d[t];
        pdata_q[t] <= pdata_d[t];
      end
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;
  assign play_data_a = pdata_q[0];
  assign play_data_b = pdata_q[1];
  assign valid_a     = valid_q[0];
  assign valid_b     = valid_q[1];
  assign len_a       = len_q[0];
  assign len_b       = len_q[1];
  assign full_a      = full_q[0];
  assign full_b      = full_q[1];
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_beat_ram_sequencer.sv
// Directed + randomized bench for beat_ram_sequencer against a sample-level
// model of two looping tracks, with a registered-read RAM attached.
module tb_beat_ram_sequencer;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int REG    = 512;

  logic              clk = 1'b0;
  logic              resetn, tick, rec_a, rec_b, play_a, play_b;
  logic [DATA_W-1:0] live_data, ram_rdata, ram_wdata, play_data_a, play_data_b;
  logic [ADDR_W-1:0] ram_addr, len_a, len_b;
  logic              ram_we, valid_a, valid_b, full_a, full_b, overrun;
  logic [DATA_W-1:0] mem [1024];

  int checks = 0;
  int errors = 0;

  // Track model: mode 0=off 1=record 2=play; samples indexed by position in the loop.
  int m_mode [2];
  int m_ptr  [2];
  int m_len  [2];
  int m_full [2];
  int m_pd   [2];
  int trk    [2][REG];
  int e_we   [2];
  int e_addr [2];
  int e_valid[2];

  always #5 clk = ~clk;

  beat_ram_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn), .tick(tick),
    .rec_a(rec_a), .rec_b(rec_b), .play_a(play_a), .play_b(play_b),
    .live_data(live_data), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .play_data_a(play_data_a), .play_data_b(play_data_b),
    .valid_a(valid_a), .valid_b(valid_b),
    .len_a(len_a), .len_b(len_b), .full_a(full_a), .full_b(full_b),
    .overrun(overrun)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      m_mode[t] = 0; m_ptr[t] = 0; m_len[t] = 0; m_full[t] = 0; m_pd[t] = 0;
    end
  endtask

  task automatic model_tick(input int d);
    for (int t = 0; t < 2; t++) begin
      int nm;
      nm = ((t == 0) ? play_a : play_b) ? 2 : (((t == 0) ? rec_a : rec_b) ? 1 : 0);
      if (nm == 0) m_ptr[t] = 0;
      else if (nm != m_mode[t]) begin
        m_ptr[t] = 0;
        if (nm == 1) begin m_len[t] = 0; m_full[t] = 0; end
      end
      m_mode[t] = nm; e_we[t] = 0; e_addr[t] = 0; e_valid[t] = 0;
      if (nm == 1 && m_full[t] == 0) begin
        e_we[t]   = 1;
        e_addr[t] = t * REG + m_ptr[t];
        trk[t][m_ptr[t]] = d;
        m_ptr[t]++;
        m_len[t] = m_ptr[t];
        if (m_len[t] == REG) m_full[t] = 1;
      end else if (nm == 2) begin
        e_valid[t] = 1;
        if (m_len[t] == 0) m_pd[t] = 0;
        else begin
          e_addr[t] = t * REG + m_ptr[t];
          m_pd[t]   = trk[t][m_ptr[t]];
          m_ptr[t]  = (m_ptr[t] + 1) % m_len[t];
        end
      end
    end
  endtask

  // Called between a negedge and the next posedge; extra!=0 re-raises tick so it is sampled 'extra' edges later.
  task automatic do_tick(input int d, input int extra);
    live_data = d[7:0];
    tick = 1'b1;
    @(posedge clk);
    model_tick(d);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check("overrun", int'(overrun), int'(extra != 0 && n == extra + 1));
      case (n)
        1: begin
          check("we_slot_a", int'(ram_we), e_we[0]);
          check("addr_slot_a", int'(ram_addr), e_addr[0]);
          if (e_we[0] != 0) check("wdata_a", int'(ram_wdata), d & 255);
        end
        2: begin
          check("we_slot_b", int'(ram_we), e_we[1]);
          check("addr_slot_b", int'(ram_addr), e_addr[1]);
          if (e_we[1] != 0) check("wdata_b", int'(ram_wdata), d & 255);
        end
        3: begin
          check("we_flush", int'(ram_we), 0);
          check("addr_flush", int'(ram_addr), 0);
          check("valid_a", int'(valid_a), e_valid[0]);
          check("valid_b_early", int'(valid_b), 0);
          if (e_valid[0] != 0) check("play_data_a", int'(play_data_a), m_pd[0]);
        end
        default: begin
          check("valid_b", int'(valid_b), e_valid[1]);
          check("valid_a_pulse", int'(valid_a), 0);
          if (e_valid[1] != 0) check("play_data_b", int'(play_data_b), m_pd[1]);
          check("len_a", int'(len_a), m_len[0]);
          check("len_b", int'(len_b), m_len[1]);
          check("full_a", int'(full_a), m_full[0]);
          check("full_b", int'(full_b), m_full[1]);
        end
      endcase
      tick = (extra != 0 && n == extra);
    end
    tick = 1'b0;
  endtask

  initial begin
    resetn = 1'b1; tick = 1'b0; rec_a = 1'b0; rec_b = 1'b0; play_a = 1'b0; play_b = 1'b0;
    live_data = '0;
    model_reset();
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", int'(ram_we), 0);
    check("rst_addr", int'(ram_addr), 0);
    check("rst_len_a", int'(len_a), 0);
    check("rst_len_b", int'(len_b), 0);
    check("rst_valid", int'({valid_a, valid_b, overrun}), 0);
    check("rst_pdata", int'({play_data_a, play_data_b}), 0);
    check("rst_full", int'({full_a, full_b}), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Record five samples on A, then loop them back.
    rec_a = 1'b1;
    for (int i = 0; i < 5; i++) do_tick(16 + i, 0);
    rec_a = 1'b0; play_a = 1'b1;
    for (int i = 0; i < 12; i++) do_tick(int'($urandom_range(0, 255)), 0);

    // Ticks landing in SLOT_A, SLOT_B and FLUSH are all dropped.
    for (int k = 1; k <= 3; k++) do_tick(int'($urandom_range(0, 255)), k);

    // Fill B's whole region while A keeps playing, then one tick past full.
    rec_b = 1'b1;
    for (int i = 0; i < REG + 1; i++) do_tick(int'($urandom_range(0, 255)), 0);
    rec_b = 1'b0; play_b = 1'b1;
    for (int i = 0; i < 6; i++) do_tick(int'($urandom_range(0, 255)), 0);

    // Random mode mixes, including simultaneous recording on both tracks.
    for (int i = 0; i < 80; i++) begin
      if (i % 8 == 0) begin
        rec_a = 1'($urandom_range(0, 1)); play_a = 1'($urandom_range(0, 1));
        rec_b = 1'($urandom_range(0, 1)); play_b = 1'($urandom_range(0, 1));
      end
      do_tick(int'($urandom_range(0, 255)), 0);
    end

    // Reset while A's write is on the bus.
    rec_a = 1'b1; rec_b = 1'b0; play_a = 1'b0; play_b = 1'b0;
    live_data = 8'h5a; tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    check("pre_rst_we", int'(ram_we), 1);
    resetn = 1'b0;
    #1;
    check("async_we_drop", int'(ram_we), 0);
    check("async_addr_drop", int'(ram_addr), 0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    check("post_rst_len_a", int'(len_a), 0);
    check("post_rst_we", int'(ram_we), 0);
    @(negedge clk);
    check("post_rst_we2", int'(ram_we), 0);

    // Playing an empty track yields zeros with no RAM access.
    rec_a = 1'b0; play_a = 1'b1;
    for (int i = 0; i < 3; i++) do_tick(int'($urandom_range(0, 255)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
